// File: rtl/mem_stage.sv
// EX/MEM pipeline register with a req/gnt/rvalid data-memory access engine.
// Optional misaligned-access trap enabled by defining MEM_ALIGN_CHECK_EN.
module mem_stage #(
    parameter int REG_AW = 5,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic              ex_we,
    input  logic [REG_AW-1:0] ex_waddr,
    input  logic [31:0]       ex_wdata,
    input  logic [3:0]        ex_mem_op,
    input  logic [31:0]       ex_store_data,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [31:0]       dmem_rdata,
    output logic              mem_we,
    output logic [REG_AW-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic              mem_misalign
);
    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef enum logic [1:0] {IDLE, REQ, RESP, DROP} state_t;
    state_t state, state_n;

    logic              is_mem, is_store, is_half, is_word, misalign, accept;
    logic [1:0]        a_raw, a_al;
    logic [ADDR_W-1:0] addr_al;
    logic [3:0]        be_n;
    logic [31:0]       wdata_n;

    // Held for the duration of a load so writeback can be formed on rvalid.
    logic [3:0]        r_op;
    logic [1:0]        r_a;
    logic              r_we;
    logic [REG_AW-1:0] r_waddr;

    assign ex_ready = (state == IDLE);
    assign accept   = ex_valid && ex_ready;

    always_comb begin
        is_mem   = (ex_mem_op >= OP_LB) && (ex_mem_op <= OP_SW);
        is_store = (ex_mem_op >= OP_SB) && (ex_mem_op <= OP_SW);
        is_half  = (ex_mem_op == OP_LH) || (ex_mem_op == OP_LHU) || (ex_mem_op == OP_SH);
        is_word  = (ex_mem_op == OP_LW) || (ex_mem_op == OP_SW);
        a_raw    = ex_wdata[1:0];
`ifdef MEM_ALIGN_CHECK_EN
        misalign = (is_half && a_raw[0]) || (is_word && (a_raw != 2'd0));
        a_al     = a_raw;
`else
        misalign = 1'b0;
        a_al     = is_word ? 2'd0 : (is_half ? {a_raw[1], 1'b0} : a_raw);
`endif
        addr_al      = ex_wdata[ADDR_W-1:0];
        addr_al[1:0] = a_al;
        if (is_word) begin
            be_n    = 4'hF;
            wdata_n = ex_store_data;
        end else if (is_half) begin
            be_n    = 4'b0011 << a_al;
            wdata_n = {2{ex_store_data[15:0]}};
        end else begin
            be_n    = 4'b0001 << a_al;
            wdata_n = {4{ex_store_data[7:0]}};
        end
    end

    function automatic logic [31:0] extract(input logic [3:0] op, input logic [1:0] a,
                                            input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[{a, 3'b000} +: 8];
        h = a[1] ? d[31:16] : d[15:0];
        case (op)
            OP_LB:   extract = {{24{b[7]}}, b};
            OP_LBU:  extract = {24'd0, b};
            OP_LH:   extract = {{16{h[15]}}, h};
            OP_LHU:  extract = {16'd0, h};
            default: extract = d;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // A flush that coincides with gnt cannot recall a load's response, so it is drained.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (accept && is_mem && !misalign && !flush) state_n = REQ;
            REQ: begin
                if (dmem_gnt) begin
                    if (dmem_we)    state_n = IDLE;
                    else if (flush) state_n = DROP;
                    else            state_n = RESP;
                end else if (flush) begin
                    state_n = IDLE;
                end
            end
            RESP: begin
                if (dmem_rvalid) state_n = IDLE;
                else if (flush)  state_n = DROP;
            end
            DROP: if (dmem_rvalid) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_be      <= 4'd0;
            dmem_wdata   <= 32'd0;
            mem_we       <= 1'b0;
            mem_waddr    <= '0;
            mem_wdata    <= 32'd0;
            mem_misalign <= 1'b0;
            r_op         <= 4'd0;
            r_a          <= 2'd0;
            r_we         <= 1'b0;
            r_waddr      <= '0;
        end else begin
            mem_we       <= 1'b0;
            mem_misalign <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && !flush) begin
                        if (!is_mem) begin
                            mem_we    <= ex_we;
                            mem_waddr <= ex_waddr;
                            mem_wdata <= ex_wdata;
                        end else if (misalign) begin
                            mem_misalign <= 1'b1;
                        end else begin
                            dmem_req   <= 1'b1;
                            dmem_we    <= is_store;
                            dmem_addr  <= addr_al;
                            dmem_be    <= be_n;
                            dmem_wdata <= wdata_n;
                            r_op       <= ex_mem_op;
                            r_a        <= a_al;
                            r_we       <= ex_we;
                            r_waddr    <= ex_waddr;
                        end
                    end
                end
                REQ: if (dmem_gnt || flush) dmem_req <= 1'b0;
                RESP: begin
                    if (dmem_rvalid && !flush) begin
                        mem_we    <= r_we;
                        mem_waddr <= r_waddr;
                        mem_wdata <= extract(r_op, r_a, dmem_rdata);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Parametrised successor to the EX->MEM pipeline register: EX/MEM register plus a data-memory access engine.
- Non-memory instructions pass through with 1-cycle latency.
- Loads and stores issue a req/gnt/rvalid transaction on the data bus and stall EX via ex_ready until complete.
- Loads are byte-lane extracted and sign/zero extended before reaching writeback (mem_we/mem_waddr/mem_wdata).

Parameters:
REG_AW, 5, register-file address width (ex_waddr/mem_waddr)
ADDR_W, 32, data-bus byte-address width; taken from ex_wdata[ADDR_W-1:0], 2..32
(data path fixed at 32 bits, 4 byte lanes, little-endian)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
flush  in  1  synchronous kill of in-flight instruction
ex_valid  in  1  EX presents an instruction
ex_ready  out  1  stage can accept (combinational: state==IDLE)
ex_we  in  1  instruction writes register file
ex_waddr  in  REG_AW  destination register
ex_wdata  in  32  ALU result; the byte address for memory ops
ex_mem_op  in  4  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 treated as none
ex_store_data  in  32  store source register value
dmem_req  out  1  request valid, held until dmem_gnt
dmem_we  out  1  1 store, 0 load
dmem_addr  out  ADDR_W  byte address
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-replicated store data
dmem_gnt  in  1  request accepted this cycle
dmem_rvalid  in  1  load data valid
dmem_rdata  in  32  load data
mem_we  out  1  writeback enable, 1-cycle pulse per retired instruction
mem_waddr  out  REG_AW  writeback register
mem_wdata  out  32  writeback data
mem_misalign  out  1  misaligned access pulse (see Optional Feature)

Behaviour:
- Reset: state IDLE. Outputs dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, mem_we, mem_waddr, mem_wdata, mem_misalign all 0. ex_ready=1 once reset is low.
- All outputs except ex_ready are registered.
- States: IDLE, REQ, RESP, DROP.
- IDLE, accept when ex_valid&&ex_ready:
  - Non-mem op accepted at cycle N: at N+1 mem_we=ex_we, mem_waddr=ex_waddr, mem_wdata=ex_wdata.
  - No accept: mem_we<=0 (bubble); mem_waddr/mem_wdata hold.
- IDLE, mem op accepted at N: at N+1 dmem_req=1 with addr/be/wdata/we latched; state REQ; mem_we=0.
- REQ: request fields stable while dmem_req=1.
  - On dmem_gnt: store -> IDLE, dmem_req=0 next cycle; load -> RESP, dmem_req=0.
  - dmem_rvalid while in REQ is ignored.
- RESP: on dmem_rvalid -> IDLE; next cycle mem_we=latched ex_we, mem_waddr=latched waddr, mem_wdata=extracted data.
- Minimum load latency: accept N, gnt at N+1, rvalid at N+2, writeback visible N+3.
- Lane rules, a=addr[1:0]:
  - LB/LBU: byte rdata[8a+:8], sign/zero extended.
  - LH/LHU: half rdata[16a[1]+:16], sign/zero extended.
  - LW: rdata.
  - SB: be=1<<a, wdata={4{byte}}.
  - SH: be=3<<a, wdata={2{half}}.
  - SW: be=4'hF, wdata=store data.
- Flush (priority below reset):
  - IDLE: the instruction accepted this cycle is discarded; mem_we=0 next cycle.
  - REQ: dmem_req drops next cycle (withdrawal before gnt is legal); -> IDLE.
  - If gnt and flush coincide in REQ: for a store the write stands, -> IDLE; for a load -> DROP.
  - RESP: -> DROP.
  - DROP: wait for dmem_rvalid, no writeback, -> IDLE. ex_ready=0 throughout.
- Reset mid-transaction: returns to IDLE; dmem_req=0 next cycle; a pending rvalid after reset is ignored.
- dmem_addr, be and wdata hold their last values when dmem_req=0.

Optional Feature:
- Macro MEM_ALIGN_CHECK_EN.
- Defined:
  - Misaligned access is LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
  - On accept it issues no dmem_req. At N+1 mem_misalign=1 for one cycle, mem_we=0, state stays IDLE.
- Undefined:
  - mem_misalign is tied 0.
  - Low address bits are forced to alignment: half clears bit0, word clears bits[1:0], applied to both dmem_addr and lane selection.

Test Plan:
- Pass-through: ex_we=1, waddr=3, wdata=0x12345678, op=0 at N -> N+1 mem_we=1, waddr=3, wdata=0x12345678; ex_ready stays 1.
- LB sign: addr=0x1003, gnt N+1, rvalid N+2 with rdata=0x80FFFFFF -> N+3 mem_wdata=0xFFFFFF80. Same access with LBU -> 0x00000080.
- SH: addr=0x2002, store_data=0x0000BEEF -> dmem_be=4'b1100, dmem_wdata=0xBEEFBEEF, dmem_we=1; gnt held off 3 cycles -> req/fields stable; ex_ready=0 until the cycle after gnt; no mem_we.
- Flush in RESP: LW in flight, flush after gnt -> rvalid rdata=0xDEADBEEF produces no mem_we; ex_ready returns 1 the cycle after rvalid.
- Back-to-back: LW then ADD (wdata=7) -> ADD accepted only after load writeback; order on mem_we is load data, then 7.
- MEM_ALIGN_CHECK_EN: LW addr=0x1002 -> mem_misalign=1 at N+1, dmem_req never asserted. Without the macro: dmem_addr=0x1000, be=4'hF.
